// File: rtl/ahb_master_port.sv
// ahb_master_port: AHB-Lite initiator for the CPU data-memory port.
// Each granted CPU request becomes one SINGLE word transfer. One address
// phase overlaps one data phase. Slave wait states hold both phases. A
// two-cycle ERROR response cancels a queued address phase, and that
// cancelled request is reported as its own error completion.
// Optional build macro AHB_MASTER_TIMEOUT_EN adds a watchdog. After
// TIMEOUT_CYCLES consecutive stalled data-phase cycles, the watchdog
// force-retires the transfer with an error.
`timescale 1ns/1ps

module ahb_master_port #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // The watchdog compares against TIMEOUT_CYCLES-1, so a limit below 2 is meaningless.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("ahb_master_port: TIMEOUT_CYCLES must be at least 2");
    end

    // Address-phase registers (what is currently driven on HADDR/HTRANS)
    logic        r_ap_valid;
    logic [31:0] r_ap_addr;
    logic        r_ap_we;
    logic [31:0] r_ap_wdata;

    // Data-phase registers (the transfer waiting for HREADY)
    logic        r_dp_valid;
    logic        r_dp_we;
    logic [31:0] r_dp_wdata;

    // A queued address phase was cancelled and still owes the CPU an error completion.
    logic        r_cancel_pend;

    // Completion registers
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_err_first;
    logic        w_abort;

    // First cycle of the two-cycle ERROR response: the slave signals ERROR with HREADY still low.
    assign w_err_first = r_dp_valid & HRESP & ~HREADY;

`ifdef AHB_MASTER_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        w_stall;

    assign w_stall = r_dp_valid & ~HREADY;
    assign w_abort = w_stall & (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Count consecutive stalled data-phase cycles; any progress or an abort restarts it.
    always_ff @(posedge HCLK) begin
        if (HRESET || !w_stall || w_abort) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    // A new address may enter only when the address slot frees at this edge.
    // Grants stop while an error is in flight or a cancel is still owed.
    // Grants also stop on a watchdog abort, so the port returns to IDLE.
    assign cpu_gnt = cpu_req & ~r_cancel_pend & ~(r_dp_valid & HRESP)
                   & (~r_ap_valid | HREADY) & ~w_abort;

    assign HADDR      = r_ap_addr;
    assign HWRITE     = r_ap_we;
    assign HTRANS     = r_ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HSIZE      = HSIZE_WORD;
    assign HBURST     = HBURST_SINGLE;
    assign HWDATA     = r_dp_wdata;
    assign cpu_rvalid = r_rvalid;
    assign cpu_rdata  = r_rdata;
    assign cpu_err    = r_err;

    // Capture the request payload on every grant; otherwise hold it, so HADDR stays stable through waits.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ap_addr  <= '0;
            r_ap_we    <= 1'b0;
            r_ap_wdata <= '0;
        end else if (cpu_gnt) begin
            r_ap_addr  <= cpu_addr;
            r_ap_we    <= cpu_we;
            r_ap_wdata <= cpu_wdata;
        end
    end

    // Advance the pipeline, apply error/timeout cancellation and generate one completion per transfer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ap_valid    <= 1'b0;
            r_dp_valid    <= 1'b0;
            r_dp_we       <= 1'b0;
            r_dp_wdata    <= '0;
            r_cancel_pend <= 1'b0;
            r_rvalid      <= 1'b0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;

            if (w_abort) begin
                // The slave is stuck: drop the data phase, report it as failed, and cancel any queued address.
                r_dp_valid <= 1'b0;
                r_rvalid   <= 1'b1;
                r_err      <= 1'b1;
                r_rdata    <= '0;
                if (r_ap_valid) begin
                    r_ap_valid    <= 1'b0;
                    r_cancel_pend <= 1'b1;
                end
            end else if (HREADY) begin
                if (r_dp_valid) begin
                    r_rvalid <= 1'b1;
                    r_err    <= HRESP;
                    r_rdata  <= r_dp_we ? 32'd0 : HRDATA;
                end
                r_dp_valid <= r_ap_valid;
                if (r_ap_valid) begin
                    r_dp_we    <= r_ap_we;
                    r_dp_wdata <= r_ap_wdata;
                end
                r_ap_valid <= cpu_gnt;
            end else begin
                if (w_err_first) begin
                    // Withdraw the pipelined address so HTRANS is IDLE in the second error cycle.
                    if (r_ap_valid) begin
                        r_ap_valid    <= 1'b0;
                        r_cancel_pend <= 1'b1;
                    end
                end else if (cpu_gnt) begin
                    r_ap_valid <= 1'b1;
                end
            end

            // The cancelled transfer reports one cycle after the data phase that caused it has left.
            if (r_cancel_pend && !r_dp_valid) begin
                r_rvalid      <= 1'b1;
                r_err         <= 1'b1;
                r_rdata       <= '0;
                r_cancel_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_master_port.sv
// tb_ahb_master_port: directed bench for ahb_master_port.
// The bench acts as the AHB slave by driving HREADY/HRESP/HRDATA directly.
// The timeout case follows the build: AHB_MASTER_TIMEOUT_EN selects the abort expectation.
`timescale 1ns/1ps

module tb_ahb_master_port;

`ifdef AHB_MASTER_TIMEOUT_EN
    localparam int unsigned TO_CYC = 8;
`else
    localparam int unsigned TO_CYC = 256;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int n_checks = 0;
    int n_errors = 0;

    ahb_master_port #(.TIMEOUT_CYCLES(TO_CYC)) u_dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .HADDR      (HADDR),
        .HWRITE     (HWRITE),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HWDATA     (HWDATA),
        .HRDATA     (HRDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic req(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req   = v;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        HRESET = 1'b1;
        req(1'b0, 1'b0, 32'd0, 32'd0);
        HRDATA = 32'd0;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        repeat (3) tick();
        HRESET = 1'b0;
        #1;
        // Reset state
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_rvalid", cpu_rvalid, 1'b0);
        chk("rst_err", cpu_err, 1'b0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_gnt", cpu_gnt, 1'b0);
        chk("hsize", HSIZE, 3'b010);
        chk("hburst", HBURST, 3'b000);

        // Case 1: zero-wait read of 0x10
        req(1'b1, 1'b0, 32'h10, 32'd0);
        HRDATA = 32'h1234_5678;
        #1;
        chk("c1_gnt", cpu_gnt, 1'b1);
        tick();
        req(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("c1_htrans", HTRANS, 2'b10);
        chk("c1_haddr", HADDR, 32'h10);
        chk("c1_hwrite", HWRITE, 1'b0);
        tick();
        chk("c1_dp_idle", HTRANS, 2'b00);
        chk("c1_rv_early", cpu_rvalid, 1'b0);
        tick();
        chk("c1_rvalid", cpu_rvalid, 1'b1);
        chk("c1_rdata", cpu_rdata, 32'h1234_5678);
        chk("c1_err", cpu_err, 1'b0);
        tick();
        chk("c1_rv_once", cpu_rvalid, 1'b0);

        // Case 2: back-to-back write 0x20 then read 0x24
        req(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5);
        #1;
        chk("c2_gnt_w", cpu_gnt, 1'b1);
        tick();
        req(1'b1, 1'b0, 32'h24, 32'd0);
        #1;
        chk("c2_gnt_r", cpu_gnt, 1'b1);
        chk("c2_haddr_w", HADDR, 32'h20);
        chk("c2_hwrite_w", HWRITE, 1'b1);
        tick();
        req(1'b0, 1'b0, 32'd0, 32'd0);
        HRDATA = 32'hCAFE_0001;
        #1;
        chk("c2_haddr_r", HADDR, 32'h24);
        chk("c2_hwdata", HWDATA, 32'hA5A5_A5A5);
        chk("c2_htrans", HTRANS, 2'b10);
        chk("c2_hwrite_r", HWRITE, 1'b0);
        tick();
        chk("c2_rv_w", cpu_rvalid, 1'b1);
        chk("c2_rdata_w", cpu_rdata, 32'd0);
        chk("c2_err_w", cpu_err, 1'b0);
        tick();
        chk("c2_rv_r", cpu_rvalid, 1'b1);
        chk("c2_rdata_r", cpu_rdata, 32'hCAFE_0001);
        tick();
        chk("c2_rv_end", cpu_rvalid, 1'b0);

        // Case 3: read 0x30 with three wait states, read 0x34 queued, 0x38 waiting
        req(1'b1, 1'b0, 32'h30, 32'd0);
        tick();
        req(1'b1, 1'b0, 32'h34, 32'd0);
        tick();
        req(1'b1, 1'b0, 32'h38, 32'd0);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("c3_wait_gnt", cpu_gnt, 1'b0);
            chk("c3_wait_haddr", HADDR, 32'h34);
            chk("c3_wait_htrans", HTRANS, 2'b10);
            chk("c3_wait_rv", cpu_rvalid, 1'b0);
            tick();
        end
        req(1'b0, 1'b0, 32'd0, 32'd0);
        HREADY = 1'b1;
        HRDATA = 32'h0BAD_F00D;
        #1;
        chk("c3_hold4_haddr", HADDR, 32'h34);
        chk("c3_hold4_htrans", HTRANS, 2'b10);
        chk("c3_hold4_rv", cpu_rvalid, 1'b0);
        tick();
        HRDATA = 32'h3434_3434;
        chk("c3_rv1", cpu_rvalid, 1'b1);
        chk("c3_rdata1", cpu_rdata, 32'h0BAD_F00D);
        tick();
        chk("c3_rv2", cpu_rvalid, 1'b1);
        chk("c3_rdata2", cpu_rdata, 32'h3434_3434);
        tick();
        chk("c3_rv_end", cpu_rvalid, 1'b0);
        chk("c3_idle", HTRANS, 2'b00);

        // Case 4: read 0x40 gets ERROR while write 0x44 sits in the address phase
        req(1'b1, 1'b0, 32'h40, 32'd0);
        tick();
        req(1'b1, 1'b1, 32'h44, 32'h4444_4444);
        tick();
        req(1'b1, 1'b0, 32'h48, 32'd0);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        HRDATA = 32'hDEAD_0040;
        #1;
        chk("c4_e1_gnt", cpu_gnt, 1'b0);
        chk("c4_e1_htrans", HTRANS, 2'b10);
        chk("c4_e1_haddr", HADDR, 32'h44);
        tick();
        HREADY = 1'b1;
        #1;
        chk("c4_e2_htrans", HTRANS, 2'b00);
        chk("c4_e2_gnt", cpu_gnt, 1'b0);
        chk("c4_e2_rv", cpu_rvalid, 1'b0);
        tick();
        HRESP = 1'b0;
        #1;
        chk("c4_rv1", cpu_rvalid, 1'b1);
        chk("c4_err1", cpu_err, 1'b1);
        chk("c4_rdata1", cpu_rdata, 32'hDEAD_0040);
        chk("c4_cancel_gnt", cpu_gnt, 1'b0);
        chk("c4_no_dp_44", (HWDATA == 32'h4444_4444), 1'b0);
        chk("c4_htrans_idle", HTRANS, 2'b00);
        tick();
        chk("c4_rv2", cpu_rvalid, 1'b1);
        chk("c4_err2", cpu_err, 1'b1);
        chk("c4_rdata2", cpu_rdata, 32'd0);
        chk("c4_gnt_back", cpu_gnt, 1'b1);
        req(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk("c4_rv_end", cpu_rvalid, 1'b0);

        // Case 5: reset while in PIPE
        req(1'b1, 1'b1, 32'h50, 32'h5555_5555);
        tick();
        req(1'b1, 1'b0, 32'h54, 32'd0);
        tick();
        req(1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("c5_pipe_htrans", HTRANS, 2'b10);
        chk("c5_pipe_hwdata", HWDATA, 32'h5555_5555);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        #1;
        chk("c5_htrans", HTRANS, 2'b00);
        chk("c5_haddr", HADDR, 32'd0);
        chk("c5_hwdata", HWDATA, 32'd0);
        chk("c5_rv0", cpu_rvalid, 1'b0);
        tick();
        chk("c5_rv1", cpu_rvalid, 1'b0);
        tick();
        chk("c5_rv2", cpu_rvalid, 1'b0);

        // Case 6: slave never becomes ready
        req(1'b1, 1'b0, 32'h60, 32'd0);
        tick();
        req(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        HREADY = 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("c6_pre_abort_rv", cpu_rvalid, 1'b0);
            tick();
        end
        chk("c6_abort_rv", cpu_rvalid, 1'b1);
        chk("c6_abort_err", cpu_err, 1'b1);
        chk("c6_abort_rdata", cpu_rdata, 32'd0);
        chk("c6_abort_idle", HTRANS, 2'b00);
        HREADY = 1'b1;
        tick();
        chk("c6_after_rv", cpu_rvalid, 1'b0);
        tick();
        chk("c6_after_rv2", cpu_rvalid, 1'b0);
`else
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cpu_rvalid) pulses++;
        end
        chk("c6_no_rvalid", pulses, 0);
        HREADY = 1'b1;
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        #1;
        chk("c6_recover_idle", HTRANS, 2'b00);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
